// File: rtl/bicubic_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bicubic_seq_ctrl_if
// Purpose  : Bus bundle between the bicubic sequencer and its surroundings:
//            image ROM read port, neighbourhood pixel stream to the kernel,
//            kernel result return and result SRAM write port.
// Ports    : rom_a/rom_q      image ROM address / data (data one cycle later)
//            pix_vld/d/last   neighbourhood pixel stream, 16 pixels per window
//            frac_x/y,den_x/y interpolation fraction numerators/denominators
//            kr_vld/kr_d      kernel result pulse and value
//            sram_a/d/wen     result SRAM write port
//            master = sequencer side, slave = environment side
// Revision : 1.0  initial release
// ============================================================================
interface bicubic_seq_ctrl_if #(
  parameter int ROM_AW = 14,
  parameter int RAM_AW = 12
);
  logic [ROM_AW-1:0] rom_a;
  logic [7:0]        rom_q;
  logic              pix_vld;
  logic [7:0]        pix_d;
  logic              pix_last;
  logic [5:0]        frac_x;
  logic [5:0]        frac_y;
  logic [5:0]        den_x;
  logic [5:0]        den_y;
  logic              kr_vld;
  logic [7:0]        kr_d;
  logic [RAM_AW-1:0] sram_a;
  logic [7:0]        sram_d;
  logic              sram_wen;

  modport master (
    output rom_a, input rom_q,
    output pix_vld, pix_d, pix_last, frac_x, frac_y, den_x, den_y,
    input  kr_vld, kr_d,
    output sram_a, sram_d, sram_wen
  );

  modport slave (
    input  rom_a, output rom_q,
    input  pix_vld, pix_d, pix_last, frac_x, frac_y, den_x, den_y,
    output kr_vld, kr_d,
    input  sram_a, sram_d, sram_wen
  );
endinterface
`default_nettype wire

// File: rtl/bicubic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bicubic_seq_ctrl
// Purpose  : Frame sequencer for the bicubic resize engine. Walks every
//            target pixel in raster order, maps it onto the source ROI with
//            an integer+remainder stepper, streams the clamped 4x4 source
//            neighbourhood to the kernel and writes the kernel result to the
//            result SRAM. DONE pulses once per frame; frames free-run.
// Ports    : CLK, RST        clock / synchronous active-high reset
//            H0,V0,SW,SH     ROI origin and size (sampled once per frame)
//            TW,TH           target size (sampled once per frame)
//            DONE            one-cycle frame-complete pulse
//            bus             ROM / pixel / kernel / SRAM bundle (master)
// Revision : 1.0  initial release
// ============================================================================
module bicubic_seq_ctrl #(
  parameter int IMG_W  = 100,
  parameter int ROM_AW = 14,
  parameter int RAM_AW = 12
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  input  wire logic [6:0] H0,
  input  wire logic [6:0] V0,
  input  wire logic [4:0] SW,
  input  wire logic [4:0] SH,
  input  wire logic [5:0] TW,
  input  wire logic [5:0] TH,
  output logic            DONE,
  bicubic_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_FETCH = 3'd1,
    S_WAITK = 3'd2,
    S_WRITE = 3'd3,
    S_STEP  = 3'd4,
    S_FIN   = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t     r_state;
  logic [6:0] r_h0, r_v0;
  logic [4:0] r_sw, r_sh;
  logic [5:0] r_tw, r_th;
  logic [5:0] r_tx, r_ty;
  logic [4:0] r_ix, r_iy;
  logic [6:0] r_rx, r_ry;     // remainders can transiently reach (T-2)+(S-1)
  logic [4:0] r_k;            // window index 0..15, 16 = fetch drain cycle
  logic       r_iss;          // an address was issued last cycle
  logic       r_iss_last;
  logic       r_norm;         // STEP is in its remainder-normalise phase

  logic [5:0] w_denx, w_deny;
  logic       w_rx_wrap, w_ry_wrap;
  logic [5:0] w_cx1, w_cy1;   // window column/row plus one (never negative)
  logic [4:0] w_cx, w_cy;
  logic [ROM_AW-1:0] w_rom_a;
  logic [RAM_AW-1:0] w_sram_a;

  assign w_denx    = r_tw - 6'd1;
  assign w_deny    = r_th - 6'd1;
  // A zero denominator means a 1-pixel target axis: never wrap.
  assign w_rx_wrap = (w_denx != 6'd0) && (r_rx >= {1'b0, w_denx});
  assign w_ry_wrap = (w_deny != 6'd0) && (r_ry >= {1'b0, w_deny});

  // Clamp of the window column/row to the ROI. The offset -1 is folded in by
  // working on value+1, so the low clamp is a compare against zero.
  always_comb begin
    w_cx1 = {1'b0, r_ix} + {4'b0, r_k[1:0]};
    w_cy1 = {1'b0, r_iy} + {4'b0, r_k[3:2]};
    if (w_cx1 == 6'd0)
      w_cx = 5'd0;
    else if ((w_cx1 - 6'd1) > {1'b0, r_sw - 5'd1})
      w_cx = r_sw - 5'd1;
    else
      w_cx = 5'(w_cx1 - 6'd1);
    if (w_cy1 == 6'd0)
      w_cy = 5'd0;
    else if ((w_cy1 - 6'd1) > {1'b0, r_sh - 5'd1})
      w_cy = r_sh - 5'd1;
    else
      w_cy = 5'(w_cy1 - 6'd1);
  end

  assign w_rom_a  = ROM_AW'((32'(r_v0) + 32'(w_cy)) * 32'(IMG_W) + 32'(r_h0) + 32'(w_cx));
  assign w_sram_a = RAM_AW'(32'(r_ty) * 32'(r_tw) + 32'(r_tx));

  // Synchronous ROM: data belongs to the address presented one cycle before,
  // which is exactly the cycle pix_vld is high.
  assign bus.pix_d = bus.pix_vld ? bus.rom_q : 8'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_LOAD;
      r_h0         <= 7'd0;
      r_v0         <= 7'd0;
      r_sw         <= 5'd0;
      r_sh         <= 5'd0;
      r_tw         <= 6'd0;
      r_th         <= 6'd0;
      r_tx         <= 6'd0;
      r_ty         <= 6'd0;
      r_ix         <= 5'd0;
      r_iy         <= 5'd0;
      r_rx         <= 7'd0;
      r_ry         <= 7'd0;
      r_k          <= 5'd0;
      r_iss        <= 1'b0;
      r_iss_last   <= 1'b0;
      r_norm       <= 1'b0;
      bus.rom_a    <= '0;
      bus.pix_vld  <= 1'b0;
      bus.pix_last <= 1'b0;
      bus.frac_x   <= 6'd0;
      bus.frac_y   <= 6'd0;
      bus.den_x    <= 6'd0;
      bus.den_y    <= 6'd0;
      bus.sram_a   <= '0;
      bus.sram_d   <= 8'd0;
      bus.sram_wen <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      r_iss        <= 1'b0;
      r_iss_last   <= 1'b0;
      bus.pix_vld  <= r_iss;
      bus.pix_last <= r_iss_last;
      bus.sram_wen <= 1'b0;
      DONE         <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_h0      <= H0;
          r_v0      <= V0;
          r_sw      <= SW;
          r_sh      <= SH;
          r_tw      <= TW;
          r_th      <= TH;
          r_tx      <= 6'd0;
          r_ty      <= 6'd0;
          r_ix      <= 5'd0;
          r_iy      <= 5'd0;
          r_rx      <= 7'd0;
          r_ry      <= 7'd0;
          r_k       <= 5'd0;
          r_norm    <= 1'b0;
          bus.den_x <= TW - 6'd1;
          bus.den_y <= TH - 6'd1;
          r_state   <= S_FETCH;
        end
        S_FETCH: begin
          bus.frac_x <= r_rx[5:0];
          bus.frac_y <= r_ry[5:0];
          if (r_k < 5'd16) begin
            bus.rom_a  <= w_rom_a;
            r_iss      <= 1'b1;
            r_iss_last <= (r_k == 5'd15);
            r_k        <= r_k + 5'd1;
          end else begin
            r_state <= S_WAITK;
          end
        end
        S_WAITK: begin
          if (bus.kr_vld) begin
            bus.sram_wen <= 1'b1;
            bus.sram_a   <= w_sram_a;
            bus.sram_d   <= bus.kr_d;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_norm  <= 1'b0;
          r_state <= S_STEP;
        end
        S_STEP: begin
          if (!r_norm) begin
            if (r_tx == w_denx) begin
              if (r_ty == w_deny) begin
                DONE    <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_tx   <= 6'd0;
                r_ix   <= 5'd0;
                r_rx   <= 7'd0;
                r_ty   <= r_ty + 6'd1;
                r_ry   <= r_ry + {2'b0, r_sh} - 7'd1;
                r_norm <= 1'b1;
              end
            end else begin
              r_tx   <= r_tx + 6'd1;
              r_rx   <= r_rx + {2'b0, r_sw} - 7'd1;
              r_norm <= 1'b1;
            end
          end else begin
            // Division-free integer part: peel one denominator per cycle.
            if (w_rx_wrap) begin
              r_rx <= r_rx - {1'b0, w_denx};
              r_ix <= r_ix + 5'd1;
            end
            if (w_ry_wrap) begin
              r_ry <= r_ry - {1'b0, w_deny};
              r_iy <= r_iy + 5'd1;
            end
            if (!w_rx_wrap && !w_ry_wrap) begin
              r_norm  <= 1'b0;
              r_k     <= 5'd0;
              r_state <= S_FETCH;
            end
          end
        end
        S_FIN:   r_state <= S_GAP;
        S_GAP:   r_state <= S_LOAD;
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bicubic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bicubic_seq_ctrl
// Purpose  : Self-checking bench for bicubic_seq_ctrl. A reference model
//            computes each window's source addresses, fractions and result
//            addresses directly from the target coordinates; kernel results
//            are random and tracked in a queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_bicubic_seq_ctrl;

  typedef struct {
    int h0; int v0; int sw; int sh; int tw; int th;
  } cfg_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] H0, V0;
  logic [4:0] SW, SH;
  logic [5:0] TW, TH;
  logic       DONE;

  bicubic_seq_ctrl_if #(.ROM_AW(14), .RAM_AW(12)) bus ();

  bicubic_seq_ctrl #(.IMG_W(100), .ROM_AW(14), .RAM_AW(12)) dut (
    .CLK(CLK), .RST(RST),
    .H0(H0), .V0(V0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
    .DONE(DONE),
    .bus(bus.master)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] romf(input int a);
    return 8'((a * 37) ^ (a >>> 5));
  endfunction

  always @(posedge CLK) bus.rom_q <= romf(int'(bus.rom_a));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // integer source position of target coordinate t: floor(t*(S-1)/(T-1))
  function automatic int ipos(input int t, input int s, input int d);
    return (d == 0) ? 0 : (t * (s - 1)) / d;
  endfunction

  function automatic int rpos(input int t, input int s, input int d);
    return (d == 0) ? 0 : (t * (s - 1)) % d;
  endfunction

  function automatic int exp_addr(input cfg_t c, input int tx, input int ty, input int k);
    int cx, cy;
    cx = clampi(ipos(tx, c.sw, c.tw - 1) - 1 + k % 4, 0, c.sw - 1);
    cy = clampi(ipos(ty, c.sh, c.th - 1) - 1 + k / 4, 0, c.sh - 1);
    return (c.v0 + cy) * 100 + c.h0 + cx;
  endfunction

  // optional directed checks on top of the model
  bit spot_en;
  int tbl [16];
  int spot_w, spot_k, spot_a;

  task automatic apply(input cfg_t c);
    H0 = 7'(c.h0); V0 = 7'(c.v0); SW = 5'(c.sw);
    SH = 5'(c.sh); TW = 6'(c.tw); TH = 6'(c.th);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rom_a"},    int'(bus.rom_a), 0);
    chk({tag, "_pix_vld"},  int'(bus.pix_vld), 0);
    chk({tag, "_pix_last"}, int'(bus.pix_last), 0);
    chk({tag, "_pix_d"},    int'(bus.pix_d), 0);
    chk({tag, "_frac_x"},   int'(bus.frac_x), 0);
    chk({tag, "_frac_y"},   int'(bus.frac_y), 0);
    chk({tag, "_den_x"},    int'(bus.den_x), 0);
    chk({tag, "_den_y"},    int'(bus.den_y), 0);
    chk({tag, "_sram_a"},   int'(bus.sram_a), 0);
    chk({tag, "_sram_d"},   int'(bus.sram_d), 0);
    chk({tag, "_sram_wen"}, int'(bus.sram_wen), 0);
    chk({tag, "_done"},     int'(DONE), 0);
  endtask

  // One frame with config c. nc is driven onto the ports halfway through so
  // the frame in flight must ignore it and the following frame must use it.
  task automatic run_frame(input cfg_t c, input cfg_t nc, input bit do_rst,
                           input int kdel, input int abort_w);
    int  w, p, nwr, ndone, kcnt, prev_a, tx, ty, nwin;
    bit  aborted, fin, applied;
    int  kq [$];
    nwin = c.tw * c.th;
    w = 0; p = 0; nwr = 0; ndone = 0; kcnt = -1;
    aborted = 0; fin = 0; applied = 0;
    if (do_rst) begin
      apply(c);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_zero("rst");
      RST = 1'b0;
    end
    prev_a = int'(bus.rom_a);
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge CLK);
      bus.kr_vld = 1'b0;
      if (kcnt > 0) begin
        kcnt--;
        if (kcnt == 0) begin
          bus.kr_vld = 1'b1; bus.kr_d = 8'($urandom);
          kq.push_back(int'(bus.kr_d)); kcnt = -1;
        end
      end
      if (bus.pix_vld) begin
        if (w < nwin) begin
          tx = w % c.tw; ty = w / c.tw;
          chk("rom_a",    prev_a, exp_addr(c, tx, ty, p));
          chk("pix_d",    int'(bus.pix_d), int'(romf(prev_a)));
          chk("pix_last", int'(bus.pix_last), (p == 15) ? 1 : 0);
          chk("frac_x",   int'(bus.frac_x), rpos(tx, c.sw, c.tw - 1));
          chk("frac_y",   int'(bus.frac_y), rpos(ty, c.sh, c.th - 1));
          chk("den_x",    int'(bus.den_x), c.tw - 1);
          chk("den_y",    int'(bus.den_y), c.th - 1);
          if (spot_en && w == 0) chk("tbl_rom_a", prev_a, tbl[p]);
          if (w == spot_w && p == spot_k) chk("spot_rom_a", prev_a, spot_a);
        end else begin
          chk("extra_pixel", w, nwin - 1);
        end
        if (p == 15) begin
          p = 0; w++;
          if (kdel == 0) begin
            bus.kr_vld = 1'b1; bus.kr_d = 8'($urandom);
            kq.push_back(int'(bus.kr_d));
          end else begin
            kcnt = kdel;
          end
        end else begin
          p++;
          // stray kernel pulse while fetching must be ignored
          if (kcnt < 0 && !bus.kr_vld && $urandom_range(3) == 0) begin
            bus.kr_vld = 1'b1; bus.kr_d = 8'($urandom);
          end
        end
      end
      if (bus.sram_wen) begin
        chk("sram_a", int'(bus.sram_a), nwr);
        if (kq.size() > 0) chk("sram_d", int'(bus.sram_d), kq.pop_front());
        else chk("sram_unexpected_write", 1, 0);
        nwr++;
        if (!applied && (abort_w < 0 || aborted) && nwr == (nwin + 1) / 2) begin
          apply(nc); applied = 1;
        end
      end
      if (DONE) begin
        ndone++;
        chk("done_after_writes", nwr, nwin);
        fin = 1;
      end
      if (!aborted && abort_w >= 0 && w == abort_w && p == 5) begin
        RST = 1'b1; bus.kr_vld = 1'b0;
        @(negedge CLK);
        check_zero("abort");
        RST = 1'b0;
        w = 0; p = 0; nwr = 0; kcnt = -1; kq.delete();
        aborted = 1;
      end
      prev_a = int'(bus.rom_a);
    end
    chk("done_count", ndone, 1);
    chk("writes", nwr, nwin);
    chk("windows", w, nwin);
  endtask

  cfg_t c1, c3, c5, ca, cb, cr, cn;

  initial begin
    RST = 1'b1; bus.kr_vld = 1'b0; bus.kr_d = 8'd0;
    spot_en = 0; spot_w = -1; spot_k = 0; spot_a = 0;
    c1 = '{0, 0, 4, 4, 7, 7};
    c3 = '{10, 20, 5, 5, 5, 5};
    c5 = '{0, 0, 3, 3, 1, 1};
    ca = '{30, 11, 9, 6, 4, 5};
    cb = '{2, 40, 1, 7, 3, 2};
    apply(c1);
    @(negedge CLK); @(negedge CLK);
    check_zero("por");

    // 4x4 ROI upscaled to 7x7; first window against literal addresses
    tbl = '{0, 0, 1, 2, 0, 0, 1, 2, 100, 100, 101, 102, 200, 200, 201, 202};
    spot_en = 1;
    run_frame(c1, c1, 1, 0, -1);
    spot_en = 0;

    // identity scale, offset ROI, slow kernel; centre of target (2,2)
    spot_w = 12; spot_k = 5; spot_a = 2212;
    run_frame(c3, c3, 1, 9, -1);
    spot_w = -1;

    // single target pixel
    run_frame(c5, c5, 1, 0, -1);

    // abort mid-fetch, then config change honoured only at the next frame
    run_frame(c1, ca, 1, 3, 2);
    run_frame(ca, cb, 0, 9, -1);
    run_frame(cb, cb, 0, 0, -1);

    // random back-to-back frames
    cr = cb;
    for (int i = 0; i < 6; i++) begin
      cn.h0 = int'($urandom_range(60)); cn.v0 = int'($urandom_range(60));
      cn.sw = int'($urandom_range(31, 1)); cn.sh = int'($urandom_range(31, 1));
      cn.tw = int'($urandom_range(10, 1)); cn.th = int'($urandom_range(10, 1));
      if (i == 0) begin
        apply(cn);
        run_frame(cn, cn, 1, int'($urandom_range(5)), -1);
      end else begin
        run_frame(cr, cn, 0, int'($urandom_range(5)), -1);
      end
      cr = cn;
    end
    run_frame(cr, cr, 0, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
